// File: rtl/ibwt_decoder_if.sv
// Streaming bus for the inverse-BWT block decoder: L-column input, reconstructed output
// and a busy status flag.
interface ibwt_decoder_if #(
    parameter int unsigned ELEMENT_LEN = 8,
    parameter int unsigned IDX_LEN     = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [ELEMENT_LEN-1:0] in_data;
    logic [IDX_LEN-1:0]     primary_idx;
    logic                   out_valid;
    logic                   out_ready;
    logic [ELEMENT_LEN-1:0] out_data;
    logic                   out_last;
    logic                   busy;

    modport master (
        output in_valid, in_data, primary_idx, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, primary_idx, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/ibwt_decoder.sv
// Inverse Burrows-Wheeler transform for fixed 32-byte blocks.
// LOAD counts symbol occurrences and per-position ranks, PREFIX turns the counts into
// first-column start offsets, WALK follows the LF mapping backwards to rebuild the text,
// EMIT streams it out in original order.
module ibwt_decoder #(
    parameter int unsigned STRING_LEN  = 32,
    parameter int unsigned ELEMENT_LEN = 8
) (
    input logic           clk,
    input logic           rst,
    ibwt_decoder_if.slave bus
);
    localparam int unsigned IDX_LEN = $clog2(STRING_LEN);
    localparam int unsigned CNT_LEN = IDX_LEN + 1;
    localparam int          NUM_SYM = 1 << ELEMENT_LEN;
    localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(STRING_LEN - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StPrefix, StWalk, StEmit} state_t;

    state_t                 state;
    logic [IDX_LEN-1:0]     byte_idx;
    logic [IDX_LEN-1:0]     walk_idx;
    logic [IDX_LEN-1:0]     emit_idx;
    logic [IDX_LEN-1:0]     p;
    logic [IDX_LEN-1:0]     prim;
    logic [ELEMENT_LEN-1:0] sym;
    logic [CNT_LEN-1:0]     run_sum;
    logic [CNT_LEN-1:0]     cnt [NUM_SYM];

    logic [ELEMENT_LEN-1:0] l_mem    [STRING_LEN];
    logic [IDX_LEN-1:0]     rank_mem [STRING_LEN];
    logic [CNT_LEN-1:0]     c_tab    [NUM_SYM];
    logic [ELEMENT_LEN-1:0] t_mem    [STRING_LEN];

    logic                   in_hs;
    logic [IDX_LEN-1:0]     wr_idx;
    logic [IDX_LEN-1:0]     next_emit;
    logic [ELEMENT_LEN-1:0] walk_sym;

    assign bus.in_ready = (state == StIdle) || (state == StLoad);
    assign bus.busy     = (state != StIdle);
    assign in_hs        = bus.in_valid && bus.in_ready;
    // Byte 0 is always the one accepted in IDLE, so the index register is only used in LOAD.
    assign wr_idx       = (state == StIdle) ? '0 : byte_idx;
    assign next_emit    = emit_idx + 1'b1;
    assign walk_sym     = l_mem[p];

    // Control FSM, symbol counters and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            byte_idx      <= '0;
            walk_idx      <= '0;
            emit_idx      <= '0;
            p             <= '0;
            prim          <= '0;
            sym           <= '0;
            run_sum       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            for (int i = 0; i < NUM_SYM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_hs) begin
                        cnt[bus.in_data] <= cnt[bus.in_data] + 1'b1;
                        prim             <= bus.primary_idx;
                        byte_idx         <= IDX_LEN'(1);
                        state            <= StLoad;
                    end
                end
                StLoad: begin
                    if (in_hs) begin
                        cnt[bus.in_data] <= cnt[bus.in_data] + 1'b1;
                        byte_idx         <= byte_idx + 1'b1;
                        if (byte_idx == LAST_IDX) begin
                            sym     <= '0;
                            run_sum <= '0;
                            state   <= StPrefix;
                        end
                    end
                end
                StPrefix: begin
                    // Counter is consumed into the running sum and cleared for the next block.
                    run_sum  <= run_sum + cnt[sym];
                    cnt[sym] <= '0;
                    sym      <= sym + 1'b1;
                    if (sym == '1) begin
                        p        <= prim;
                        walk_idx <= LAST_IDX;
                        state    <= StWalk;
                    end
                end
                StWalk: begin
                    p        <= IDX_LEN'(c_tab[walk_sym] + CNT_LEN'(rank_mem[p]));
                    walk_idx <= walk_idx - 1'b1;
                    if (walk_idx == '0) begin
                        emit_idx <= '0;
                        state    <= StEmit;
                    end
                end
                StEmit: begin
                    // First EMIT cycle loads T[0] into the output register.
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= t_mem[0];
                        bus.out_last  <= (LAST_IDX == '0);
                    end else if (bus.out_ready) begin
                        if (emit_idx == LAST_IDX) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            emit_idx      <= '0;
                            state         <= StIdle;
                        end else begin
                            emit_idx     <= next_emit;
                            bus.out_data <= t_mem[next_emit];
                            bus.out_last <= (next_emit == LAST_IDX);
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Block storage: L column, ranks, first-column offsets and the rebuilt text.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            l_mem[wr_idx]    <= bus.in_data;
            rank_mem[wr_idx] <= cnt[bus.in_data][IDX_LEN-1:0];
        end
        if (state == StIdle && in_hs) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                c_tab[i] <= '0;
            end
        end
        if (state == StPrefix) begin
            c_tab[sym] <= run_sum;
        end
        if (state == StWalk) begin
            t_mem[walk_idx] <= walk_sym;
        end
    end
endmodule

// File: doc/ibwt_decoder.md
IBWT_DECODER -- requirements
Module: ibwt_decoder

Interface
REQ-001 SHALL have parameter STRING_LEN, default 32, number of bytes per block; only 32 is supported.
REQ-002 SHALL have parameter ELEMENT_LEN, default 8, symbol width in bits.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  in_data and primary_idx are valid.
REQ-007 in_ready  output  1  block accepts an input byte this cycle.
REQ-008 in_data  input  8  next symbol of the BWT last column L, index 0 first.
REQ-009 primary_idx  input  5  sorted-row index of the original string; sampled with byte 0 only.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  8  next reconstructed byte, original order, index 0 first.
REQ-013 out_last  output  1  high together with out_valid on byte 31.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, PREFIX, WALK, EMIT; a handshake is valid&&ready at a rising edge.
REQ-016 in_ready SHALL be 1 in IDLE and LOAD and 0 otherwise; in_valid outside IDLE/LOAD SHALL be ignored.
REQ-017 IDLE: the first input handshake SHALL store L[0], latch primary_idx and go to LOAD.
REQ-018 Each input handshake with byte index i SHALL store L[i], set rank[i] = cnt[L[i]] (5 bits) and increment cnt[L[i]] (256 x 6-bit counters).
REQ-019 The handshake of byte 31 SHALL move the FSM to PREFIX; LOAD with in_valid low SHALL hold state.
REQ-020 PREFIX SHALL last exactly 256 cycles, symbol c = 0..255: C[c] = running sum of cnt[0..c-1] (6 bits), and cnt[c] SHALL be cleared to 0 in the same cycle.
REQ-021 WALK SHALL last exactly 32 cycles: p starts at primary_idx; for k = 31 down to 0: T[k] = L[p], then p = C[L[p]] + rank[p], truncated to 5 bits.
REQ-022 EMIT: out_valid SHALL be 1; out_data = T[j] with j starting at 0; j SHALL advance only on an output handshake.
REQ-023 With out_ready low, out_data and out_last SHALL hold stable.
REQ-024 The handshake with j = 31 SHALL return the FSM to IDLE; in_ready SHALL be 1 in the next cycle.
REQ-025 out_valid SHALL first rise exactly 289 rising edges after the edge that accepted byte 31 (256 PREFIX + 32 WALK + 1).
REQ-026 With continuous out_ready, EMIT SHALL take exactly 32 cycles.
REQ-027 An L/primary_idx pair that is not a valid BWT SHALL still produce exactly 32 output bytes and return to IDLE without hanging.
REQ-028 The counter and C tables SHALL be all-zero at entry to every LOAD.

Reset
REQ-029 On rst high, regardless of state, the following SHALL clear to 0 immediately: FSM (IDLE), byte/walk/emit indices, all 256 cnt entries, p, out_valid, out_last and busy.
REQ-030 in_ready SHALL be 1 after reset is released.
REQ-031 rst mid-LOAD, mid-PREFIX, mid-WALK or mid-EMIT SHALL discard the block; no further output beats SHALL be produced for it.
REQ-032 L, rank, C and T storage need not be reset.

Verification
REQ-033 L = 0x1F,0x00,0x01..0x1E, primary_idx=0, out_ready=1 -> out_data 0x00..0x1F; out_last on 0x1F; out_valid rises 289 edges after the last input.
REQ-034 L = 0x01,0x02..0x1F,0x00, primary_idx=31 -> out_data 0x1F down to 0x00.
REQ-035 32 x 0x41, primary_idx=0 -> 32 x 0x41; then a second block (REQ-033 data) decodes correctly, proving cnt clear.
REQ-036 REQ-033 data with out_ready toggled at random -> same sequence; data stable while stalled; exactly 32 handshakes.
REQ-037 rst asserted during PREFIX, then REQ-034 data -> correct REQ-034 output; no stale out_valid.
REQ-038 in_valid gaps during LOAD and in_valid high during WALK/EMIT -> gaps tolerated, extra bytes ignored, output unchanged.
